bcd_code_conv: RTL and testbench
================================

# bcd_code_conv

Multi-digit, sequential BCD code converter. It accepts a packed word of `DIGITS` BCD digits and converts one digit per clock, least-significant digit first, into 2421 (Aiken), excess-3 or pass-through code. Results go out on a valid/ready handshake. It sits between a BCD source, such as a keypad or counter, and display/encoding logic that needs self-complementing codes. It generalises the single-digit combinational BCD-to-2421 stage to N digits with mode select, flow control and optional invalid-digit detection.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits per word; legal range 1..16.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: source presents a word.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `in_bcd`  in  4*DIGITS: packed BCD; digit i is bits [4i+3:4i].
- `mode`  in  2: code select, sampled on accept. 00 = 2421; 01 = excess-3; 10 and 11 = pass-through.
- `out_valid`  out  1: converted word available.
- `out_ready`  in  1: sink accepts the word.
- `out_code`  out  4*DIGITS: converted word, same digit packing as `in_bcd`.
- `err`  out  1: at least one input digit > 9; valid while `out_valid` is high.

## Operation
- FSM states are IDLE, CONV and DONE.
- IDLE to CONV on `in_valid && in_ready`. On that edge: latch `in_bcd` and `mode`, clear digit index to 0, clear the `err` accumulator.
- CONV: each cycle convert digit[index] into the output register, then increment index. After digit `DIGITS-1`, go to DONE.
- DONE: `out_valid`=1. `out_code` and `err` are held stable until `out_valid && out_ready`, then go to IDLE.
- There is no input/output overlap: `in_ready`=0 in CONV and DONE.
- Per-digit mapping for d in 0..9:
  - 2421: d<5 gives d; d>=5 gives d+6.
  - Excess-3: d+3, 4-bit result.
  - Pass-through: d.
- Invalid digits (10..15) are handled according to Configuration.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_code`=0, `err`=0, index 0.
- Asserting `rst_n` low mid-conversion aborts the conversion immediately. No partial result is emitted.
- `mode` or `in_bcd` changing after accept has no effect on the word in flight.

## Timing
- The accept edge is T. Digit i is written at edge T+1+i.
- `out_valid` rises after edge T+DIGITS. Latency from accept to `out_valid` is `DIGITS` cycles.
- If `out_ready` is already high, the word is consumed at edge T+DIGITS+1 and the block returns to IDLE. The next accept can then occur at edge T+DIGITS+2.
- Throughput is one word per DIGITS+2 cycles when `in_valid` and `out_ready` are held high.
- `out_valid` is registered. No combinational path exists from `out_ready` to `in_ready`, or from `in_valid` to any output.
- Unwritten higher digits of `out_code` during CONV are don't-care. Only the DONE state value is specified.

## Configuration
- Macro `BCD_CODE_CONV_ERR_EN`.
- Defined:
  - Any digit in 10..15 sets `err` for that word.
  - That digit's output is 4'hF in every mode.
  - `err` is cleared on the next accept and on reset.
- Undefined:
  - `err` is tied to 0.
  - Invalid digits pass through unchanged in every mode.
  - No error logic is synthesised.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. Expect `in_ready`=1, `out_valid`=0, `out_code`=0, `err`=0.
- 2421 mode, DIGITS=4: `in_bcd`=16'h1957, `mode`=00, `out_ready`=1. Expect `out_valid` 4 cycles after accept, `out_code`=16'h1FBD, `err`=0.
- Excess-3 and pass-through: `in_bcd`=16'h1957 with `mode`=01 gives 16'h4C8A. With `mode`=10 it gives 16'h1957. Change `mode` during CONV and confirm there is no effect.
- Invalid digit: `in_bcd`=16'h12A4, `mode`=00. With macro: `out_code`=16'h12F4, `err`=1. Next word 16'h0000 gives `err`=0. Without macro: `out_code`=16'h12A4, `err`=0.
- Backpressure: `out_ready`=0 for 5 cycles in DONE. Expect `out_code` stable, `in_ready`=0, and a new `in_valid` not accepted. Raise `out_ready`: one transfer, then IDLE.
- Mid-operation reset: pulse `rst_n` low at the 2nd CONV cycle. Expect immediate reset values, no `out_valid`, and a correct result for the next word 16'h9999 in mode 00 (16'hFFFF).

Source files
------------

// File: rtl/bcd_code_conv.sv
// bcd_code_conv
//   Converts a packed word of DIGITS BCD digits into another code. It handles
//   one digit per clock, starting with the least-significant digit. The result
//   is returned on a valid/ready handshake.
//   Codes selected by mode:
//     00 = 2421 (Aiken)
//     01 = excess-3
//     10 and 11 = pass-through
//   Optional feature macro: BCD_CODE_CONV_ERR_EN
//     When defined, invalid digits (10..15) raise err and convert to 4'hF.
//     When undefined, invalid digits pass through and err is tied to 0.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   source presents a word
//   in_ready   block can accept a word (IDLE only)
//   in_bcd     packed BCD; digit i is in_bcd[4i+3:4i]
//   mode       code select, sampled on accept
//   out_valid  converted word available (DONE)
//   out_ready  sink accepts the word
//   out_code   converted word, same packing as in_bcd
//   err        some input digit was > 9; valid while out_valid is high
module bcd_code_conv #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic                  err
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [1:0]           mode_q;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           cur_digit;
  logic [3:0]           cur_code;
  logic                 cur_bad;
  logic                 accept;

  // Status flags are decoded from the state register only, so no
  // combinational path exists from in_valid or out_ready to any output.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Digit select. {idx, 2'b00} equals 4*idx without widening idx.
  assign cur_digit = bcd_q[{idx, 2'b00} +: 4];
  assign cur_bad   = (cur_digit > 4'd9);

  // Per-digit conversion.
  always_comb begin
    cur_code = cur_digit;
    if (!cur_bad) begin
      case (mode_q)
        2'b00:   if (cur_digit >= 4'd5) cur_code = cur_digit + 4'd6;
        2'b01:   cur_code = cur_digit + 4'd3;
        default: cur_code = cur_digit;
      endcase
    end
`ifdef BCD_CODE_CONV_ERR_EN
    else begin
      cur_code = 4'hF;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= '0;
      mode_q   <= '0;
      idx      <= '0;
      out_code <= '0;
    end else if (accept) begin
      bcd_q  <= in_bcd;
      mode_q <= mode;
      idx    <= '0;
    end else if (state == CONV) begin
      out_code[{idx, 2'b00} +: 4] <= cur_code;
      idx                         <= idx + 1'b1;
    end
  end

`ifdef BCD_CODE_CONV_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               err_q <= 1'b0;
    else if (accept)          err_q <= 1'b0;
    else if (state == CONV)   err_q <= err_q | cur_bad;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_code_conv.sv
// tb_bcd_code_conv
//   Directed self-checking bench for bcd_code_conv with DIGITS = 4.
//   Expected words are hand-computed. Results that depend on invalid digits
//   follow BCD_CODE_CONV_ERR_EN.
module tb_bcd_code_conv;

  localparam int unsigned DIGITS = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  in_bcd;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  out_code;
  logic                 err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bcd_code_conv #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word with out_ready already high.
  // Scrambles mode and in_bcd right after accept.
  // Checks latency, result, and the return to IDLE.
  task automatic run_word(input string tag, input logic [15:0] bcd, input logic [1:0] m,
                          input logic [15:0] exp_code, input logic exp_err);
    int unsigned lat;
    chk({tag, "/ready_before"}, in_ready, 1);
    in_bcd    = bcd;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_bcd   = ~bcd;
    mode     = ~m;
    chk({tag, "/ready_in_conv"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "/latency"}, lat, DIGITS);
    chk({tag, "/code"}, out_code, exp_code);
    chk({tag, "/err"}, err, exp_err);
    step();
    chk({tag, "/valid_after"}, out_valid, 0);
    chk({tag, "/ready_after"}, in_ready, 1);
  endtask

  initial begin
    int unsigned lat;
    logic        saw_valid;
    logic [15:0] held;

    // Reset with random inputs.
    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    in_bcd    = 16'($urandom);
    mode      = 2'($urandom);
    out_ready = 1'($urandom);
    step();
    step();
    chk("rst/in_ready", in_ready, 1);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/out_code", out_code, 16'h0000);
    chk("rst/err", err, 0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();

    // Main conversions. Each run also scrambles mode and in_bcd after accept.
    run_word("aiken_1957", 16'h1957, 2'b00, 16'h1FBD, 1'b0);
    run_word("xs3_1957",   16'h1957, 2'b01, 16'h4C8A, 1'b0);
    run_word("pass_1957",  16'h1957, 2'b10, 16'h1957, 1'b0);
    run_word("pass11_8642", 16'h8642, 2'b11, 16'h8642, 1'b0);
    run_word("xs3_9000",   16'h9000, 2'b01, 16'hC333, 1'b0);
    run_word("aiken_0234", 16'h0234, 2'b00, 16'h0234, 1'b0);

    // Invalid digits.
`ifdef BCD_CODE_CONV_ERR_EN
    run_word("bad_12A4",     16'h12A4, 2'b00, 16'h12F4, 1'b1);
    run_word("clr_0000",     16'h0000, 2'b00, 16'h0000, 1'b0);
    run_word("bad_xs3_12A4", 16'h12A4, 2'b01, 16'h45F7, 1'b1);
`else
    run_word("bad_12A4",     16'h12A4, 2'b00, 16'h12A4, 1'b0);
    run_word("clr_0000",     16'h0000, 2'b00, 16'h0000, 1'b0);
    run_word("bad_xs3_12A4", 16'h12A4, 2'b01, 16'h45A7, 1'b0);
`endif

    // Backpressure: hold out_ready low in DONE while offering another word.
    out_ready = 1'b0;
    in_bcd    = 16'h0234;
    mode      = 2'b00;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp/latency", lat, DIGITS);
    held = out_code;
    chk("bp/code", held, 16'h0234);
    in_bcd   = 16'h5678;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp/valid_hold", out_valid, 1);
      chk("bp/ready_low", in_ready, 0);
      chk("bp/code_stable", out_code, 16'h0234);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp/valid_drop", out_valid, 0);
    chk("bp/idle_ready", in_ready, 1);
    step();
    chk("bp/no_accept", in_ready, 1);
    run_word("aiken_5678", 16'h5678, 2'b00, 16'hBCDE, 1'b0);

    // Reset during the second CONV cycle.
    in_bcd    = 16'h1957;
    mode      = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst/in_ready", in_ready, 1);
    chk("midrst/out_valid", out_valid, 0);
    chk("midrst/out_code", out_code, 16'h0000);
    chk("midrst/err", err, 0);
    step();
    #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst/no_valid", saw_valid, 0);
    run_word("aiken_9999", 16'h9999, 2'b00, 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
